// File: rtl/dm_line_arbiter.sv
// dm_line_arbiter: two-port arbiter and line burst sequencer for the
// single-ported 8K x 16 data memory shared by two D-cache controllers.
// Ports: clk, rst (sync, active-high)
//   req0/rw0/addr0/wdata0 -> ack0/rvld0/done0   (requester 0)
//   req1/rw1/addr1/wdata1 -> ack1/rvld1/done1   (requester 1)
//   rdata, beat                                 (shared, qualify by rvld)
//   dm_addr/dm_re/dm_we/dm_wdata -> DM, dm_rdata <- DM
// Build option: DM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins)
// instead of round-robin.
module dm_line_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 16,
  parameter int LINE_WORDS = 4,
  localparam int LB        = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          rvld0,
  output logic          done0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          rvld1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [LB-1:0] beat,
  output logic [AW-1:0] dm_addr,
  output logic          dm_re,
  output logic          dm_we,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  localparam logic [LB-1:0] LAST = LB'(LINE_WORDS - 1);

  state_t           state;
  logic             gnt;
  logic             op_wr;
  logic             rvld_q;
  logic [AW-LB-1:0] base;
  logic [LB-1:0]    beat_q;
  logic [DW-1:0]    rdata_q;

  logic pick;
  logic busy;
  logic last;
  logic done_any;

  // Word offset bits of the line address are don't-care.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{addr0[LB-1:0], addr1[LB-1:0]};

`ifdef DM_ARB_FIXED_PRIO_EN
  // Port 0 always wins; port 1 can starve behind a port-0 stream.
  assign pick = ~req0;
`else
  logic rr_ptr;

  assign pick = (req0 & req1) ? rr_ptr : req1;

  // The port that just finished yields to the other one next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (done_any) begin
      rr_ptr <= ~gnt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      op_wr   <= 1'b0;
      base    <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rvld_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt    <= pick;
            op_wr  <= pick ? rw1 : rw0;
            base   <= pick ? addr1[AW-1:LB] : addr0[AW-1:LB];
            beat_q <= '0;
            state  <= BURST;
          end
        end
        BURST: begin
          // Beat counter wraps inside the line.
          beat_q <= beat_q + 1'b1;
          if (!op_wr) begin
            // DM produced this word at the preceding negedge.
            rdata_q <= dm_rdata;
            rvld_q  <= 1'b1;
          end
          if (last) begin
            state <= op_wr ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == BURST);
  assign last     = (beat_q == LAST);
  assign done_any = (busy & op_wr & last) | (state == DRAIN);

  assign dm_re    = busy & ~op_wr;
  assign dm_we    = busy & op_wr;
  assign dm_addr  = busy ? {base, beat_q} : '0;
  assign dm_wdata = dm_we ? (gnt ? wdata1 : wdata0) : '0;

  assign ack0  = busy & ~gnt;
  assign ack1  = busy & gnt;
  assign rvld0 = rvld_q & ~gnt;
  assign rvld1 = rvld_q & gnt;
  assign done0 = done_any & ~gnt;
  assign done1 = done_any & gnt;

  assign rdata = rdata_q;
  assign beat  = beat_q;

endmodule

// File: tb/tb_dm_line_arbiter.sv
// tb_dm_line_arbiter: self-checking bench for dm_line_arbiter with a
// behavioural DM model, requester drivers and a reference memory.
module tb_dm_line_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int LB = 2;

  logic clk = 1'b0;
  logic rst;
  logic req[2];
  logic rw[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2];
  logic ack[2];
  logic rvld[2];
  logic done[2];
  logic [DW-1:0] rdata;
  logic [LB-1:0] beat;
  logic [AW-1:0] dm_addr;
  logic dm_re;
  logic dm_we;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  logic [DW-1:0] mem [0:8191];
  logic [DW-1:0] ref_mem [0:8191];
  bit mem_ready = 1'b0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dm_line_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .rw0(rw[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .ack0(ack[0]), .rvld0(rvld[0]), .done0(done[0]),
    .req1(req[1]), .rw1(rw[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .ack1(ack[1]), .rvld1(rvld[1]), .done1(done[1]),
    .rdata(rdata), .beat(beat),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // DM model: write and read both take effect at negedge.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 16'(i * 37 + 23130);
      mem_ready <= 1'b1;
    end else begin
      if (dm_we) mem[dm_addr] <= dm_wdata;
      if (dm_re) dm_rdata <= mem[dm_addr];
    end
  end

  // Global invariants: one DM op at a time, one port active at a time.
  always @(negedge clk) begin
    if (cyc > 2) begin
      n_checks++;
      if ((dm_re && dm_we) ||
          ((ack[0] | rvld[0] | done[0]) && (ack[1] | rvld[1] | done[1])) ||
          (!dm_we && dm_wdata !== '0))
        $display("FAIL invariant cyc=%0d re=%b we=%b p0=%b%b%b p1=%b%b%b wd=%h required exclusive ops, idle wdata 0",
                 cyc, dm_re, dm_we, ack[0], rvld[0], done[0],
                 ack[1], rvld[1], done[1], dm_wdata);
      else n_pass++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Requester model: raise req, follow acks, drop req after done.
  task automatic port_burst(
    input int p, input bit w, input logic [AW-1:0] a,
    input logic [LW-1:0][DW-1:0] wd, input bit keep,
    output logic [LW-1:0][DW-1:0] rd, output logic [LW-1:0][AW-1:0] ad,
    output int n_ack, output int n_rvld,
    output int t_ack, output int t_rvld, output int t_done,
    output bit bad_op);
    bit got;
    got = 1'b0;
    n_ack = 0; n_rvld = 0;
    t_ack = -1; t_rvld = -1; t_done = -1;
    bad_op = 1'b0; rd = '0; ad = '0;
    if (!req[p]) begin
      @(posedge clk); #1;
    end
    req[p] = 1'b1; rw[p] = w; addr[p] = a; wdata[p] = wd[0];
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (ack[p]) begin
        if (t_ack < 0) t_ack = cyc;
        if (n_ack < LW) ad[n_ack] = dm_addr;
        if (dm_we !== w || dm_re !== !w) bad_op = 1'b1;
        n_ack++;
      end
      if (rvld[p]) begin
        if (t_rvld < 0) t_rvld = cyc;
        if (n_rvld < LW) rd[n_rvld] = rdata;
        n_rvld++;
      end
      if (done[p]) begin
        t_done = cyc;
        got = 1'b1;
      end
      @(posedge clk); #1;
      // Granted-port control changes mid-burst must be ignored.
      if (n_ack > 0) begin
        addr[p] = AW'($urandom);
        rw[p] = 1'($urandom_range(0, 1));
      end
      wdata[p] = (n_ack < LW) ? wd[n_ack] : 16'hDEAD;
      if (got && !keep) req[p] = 1'b0;
    end
    if (!got) req[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req[0] = 1'b1; req[1] = 1'b1; rw[0] = 1'b1; rw[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ack[0], rvld[0], done[0], ack[1], rvld[1], done[1]} !== 6'b0)
      $display("FAIL reset_handshake got %b%b%b%b%b%b required 000000",
               ack[0], rvld[0], done[0], ack[1], rvld[1], done[1]);
    else n_pass++;
    n_checks++;
    if (dm_re !== 1'b0 || dm_we !== 1'b0 || dm_addr !== '0 || dm_wdata !== '0)
      $display("FAIL reset_dm got re=%b we=%b addr=%h wd=%h required all 0",
               dm_re, dm_we, dm_addr, dm_wdata);
    else n_pass++;
    n_checks++;
    if (rdata !== '0 || beat !== '0)
      $display("FAIL reset_regs got rdata=%h beat=%0d required 0/0", rdata, beat);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_p0();
    logic [LW-1:0][DW-1:0] wd, rd;
    logic [LW-1:0][AW-1:0] ad;
    int na, nr, ta, tr, td;
    bit bo;
    wd = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    port_burst(0, 1'b1, 13'h0105, wd, 1'b0, rd, ad, na, nr, ta, tr, td, bo);
    n_checks++;
    if (td < 0 || na != 4 || nr != 0 || td != ta + 3)
      $display("FAIL write_p0_timing got na=%0d nr=%0d ta=%0d td=%0d required 4/0/td=ta+3",
               na, nr, ta, td);
    else n_pass++;
    n_checks++;
    if (bo) $display("FAIL write_p0_op got bad re/we during beat required we only");
    else n_pass++;
    for (int i = 0; i < LW; i++) begin
      n_checks++;
      if (ad[i] !== 13'(16'h0104 + i) || mem[16'h0104 + i] !== 16'(16'hA000 + i))
        $display("FAIL write_p0_beat%0d got addr=%h mem=%h required %h/%h",
                 i, ad[i], mem[16'h0104 + i], 16'h0104 + i, 16'hA000 + i);
      else n_pass++;
      ref_mem[16'h0104 + i] = 16'(16'hA000 + i);
    end
  endtask

  task automatic test_read_p1();
    logic [LW-1:0][DW-1:0] wd, rd;
    logic [LW-1:0][AW-1:0] ad;
    int na, nr, ta, tr, td;
    bit bo;
    wd = '0;
    port_burst(1, 1'b0, 13'h0104, wd, 1'b0, rd, ad, na, nr, ta, tr, td, bo);
    n_checks++;
    if (td < 0 || na != 4 || nr != 4 || tr != ta + 1 || td != tr + 3)
      $display("FAIL read_p1_timing got na=%0d nr=%0d ta=%0d tr=%0d td=%0d required 4/4 tr=ta+1 td=tr+3",
               na, nr, ta, tr, td);
    else n_pass++;
    n_checks++;
    if (bo) $display("FAIL read_p1_op got dm_we during read required re only");
    else n_pass++;
    for (int i = 0; i < LW; i++) begin
      n_checks++;
      if (rd[i] !== 16'(16'hA000 + i) || ad[i] !== 13'(16'h0104 + i))
        $display("FAIL read_p1_word%0d got data=%h addr=%h required %h/%h",
                 i, rd[i], ad[i], 16'hA000 + i, 16'h0104 + i);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [LW-1:0][DW-1:0] wd, rd;
    logic [LW-1:0][AW-1:0] ad;
    int na, nr, ta, tr, td;
    bit bo;
    for (int i = 0; i < LW; i++) wd[i] = DW'($urandom);
    port_burst(1, 1'b1, 13'h1FFE, wd, 1'b0, rd, ad, na, nr, ta, tr, td, bo);
    for (int i = 0; i < LW; i++) ref_mem[8188 + i] = wd[i];
    port_burst(0, 1'b0, 13'h1FFF, wd, 1'b0, rd, ad, na, nr, ta, tr, td, bo);
    n_checks++;
    if (td < 0 || na != 4 || nr != 4)
      $display("FAIL wrap_timing got na=%0d nr=%0d td=%0d required 4/4/done", na, nr, td);
    else n_pass++;
    for (int i = 0; i < LW; i++) begin
      n_checks++;
      if (ad[i] !== 13'(8188 + i) || rd[i] !== ref_mem[8188 + i])
        $display("FAIL wrap_beat%0d got addr=%h data=%h required %h/%h",
                 i, ad[i], rd[i], 8188 + i, ref_mem[8188 + i]);
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    logic [LW-1:0][DW-1:0] wd, rda, rdb, rdc;
    logic [LW-1:0][AW-1:0] ada, adb, adc;
    int naa, nra, taa, tra, tda, nab, nrb, tab, trb, tdb, nac, nrc, tac, trc, tdc;
    bit boa, bob, boc;
    for (int i = 0; i < LW; i++) wd[i] = DW'($urandom);
    do_reset();
    fork
      begin
        port_burst(0, 1'b1, 13'h0200, wd, 1'b0, rda, ada, naa, nra, taa, tra, tda, boa);
        port_burst(0, 1'b0, 13'h0300, wd, 1'b0, rdc, adc, nac, nrc, tac, trc, tdc, boc);
      end
      port_burst(1, 1'b0, 13'h0104, wd, 1'b0, rdb, adb, nab, nrb, tab, trb, tdb, bob);
    join
    for (int i = 0; i < LW; i++) ref_mem[16'h0200 + i] = wd[i];
    n_checks++;
    if (tda < 0 || tdb < 0 || tdc < 0 || taa >= tab)
      $display("FAIL contention_first got t0=%0d t1=%0d done=%0d/%0d/%0d required port 0 first",
               taa, tab, tda, tdb, tdc);
    else n_pass++;
    n_checks++;
    if (tab != tda + 2)
      $display("FAIL contention_second got t_ack1=%0d required %0d", tab, tda + 2);
    else n_pass++;
    n_checks++;
    if (tac != tdb + 2)
      $display("FAIL contention_rereq got t_ack0=%0d required %0d", tac, tdb + 2);
    else n_pass++;
    n_checks++;
    if (rdb[0] !== 16'hA000 || rdb[3] !== 16'hA003 || rdc[2] !== ref_mem[16'h0302])
      $display("FAIL contention_data got %h %h %h required A000 A003 %h",
               rdb[0], rdb[3], rdc[2], ref_mem[16'h0302]);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [LW-1:0][DW-1:0] wd, rd;
    logic [LW-1:0][AW-1:0] ad;
    int na, nr, tr, nb, nrb, tab, trb, tdb;
    int ta[3], td[3];
    int e1, e01, e02;
    bit bo, bob;
    for (int i = 0; i < LW; i++) wd[i] = DW'($urandom);
    do_reset();
    fork
      begin
        port_burst(0, 1'b0, 13'h0800, wd, 1'b1, rd, ad, na, nr, ta[0], tr, td[0], bo);
        port_burst(0, 1'b0, 13'h0804, wd, 1'b1, rd, ad, na, nr, ta[1], tr, td[1], bo);
        port_burst(0, 1'b0, 13'h0808, wd, 1'b0, rd, ad, na, nr, ta[2], tr, td[2], bo);
      end
      port_burst(1, 1'b1, 13'h0900, wd, 1'b0, rd, ad, nb, nrb, tab, trb, tdb, bob);
    join
    for (int i = 0; i < LW; i++) ref_mem[16'h0900 + i] = wd[i];
`ifdef DM_ARB_FIXED_PRIO_EN
    e01 = td[0] + 2;
    e02 = td[1] + 2;
    e1 = td[2] + 2;
`else
    e1 = td[0] + 2;
    e01 = tdb + 2;
    e02 = td[1] + 2;
`endif
    n_checks++;
    if (tab != e1)
      $display("FAIL stream_port1 got t_ack1=%0d required %0d", tab, e1);
    else n_pass++;
    n_checks++;
    if (ta[1] != e01 || ta[2] != e02 || td[2] < 0 || tdb < 0)
      $display("FAIL stream_port0 got t_ack=%0d/%0d required %0d/%0d",
               ta[1], ta[2], e01, e02);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic [LW-1:0][DW-1:0] wd;
    int k;
    bit saw_done;
    for (int i = 0; i < LW; i++) wd[i] = ~ref_mem[16'h0400 + i];
    k = 0;
    saw_done = 1'b0;
    @(posedge clk); #1;
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 13'h0402; wdata[0] = wd[0];
    for (int c = 0; c < 50 && k < 2; c++) begin
      @(negedge clk);
      if (done[0]) saw_done = 1'b1;
      if (ack[0]) k++;
      if (k < 2) begin
        @(posedge clk); #1;
        wdata[0] = wd[k];
      end
    end
    // Reset lands on the edge that would start beat 2.
    rst = 1'b1;
    @(posedge clk); #1;
    wdata[0] = wd[2];
    @(negedge clk);
    if (done[0]) saw_done = 1'b1;
    n_checks++;
    if (k != 2 || dm_we !== 1'b0 || ack[0] !== 1'b0 || done[0] !== 1'b0 || beat !== '0)
      $display("FAIL midrst_outputs got k=%0d we=%b ack=%b done=%b beat=%0d required 2/0/0/0/0",
               k, dm_we, ack[0], done[0], beat);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0;
    repeat (3) @(negedge clk);
    if (done[0]) saw_done = 1'b1;
    ref_mem[16'h0400] = wd[0];
    ref_mem[16'h0401] = wd[1];
    n_checks++;
    if (saw_done)
      $display("FAIL midrst_done got done pulse required none");
    else n_pass++;
    for (int i = 0; i < LW; i++) begin
      n_checks++;
      if (mem[16'h0400 + i] !== ref_mem[16'h0400 + i])
        $display("FAIL midrst_mem%0d got %h required %h",
                 i, mem[16'h0400 + i], ref_mem[16'h0400 + i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [LW-1:0][DW-1:0] wdv[2], rdv[2], expv[2];
    logic [LW-1:0][AW-1:0] adv[2];
    logic [AW-1:0] av[2], la[2];
    int nav[2], nrv[2], tav[2], trv[2], tdv[2];
    bit bov[2], wv[2], use_p[2];
    int mode, win, last_p;
    do_reset();
    last_p = 1;
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 2);
      use_p[0] = (mode != 1);
      use_p[1] = (mode != 0);
      av[0] = AW'($urandom);
      av[1] = AW'(av[0] + LW * $urandom_range(1, 400));
      for (int p = 0; p < 2; p++) begin
        wv[p] = 1'($urandom_range(0, 1));
        la[p] = AW'(av[p] - (av[p] % LW));
        for (int i = 0; i < LW; i++) begin
          wdv[p][i] = DW'($urandom);
          expv[p][i] = ref_mem[la[p] + i];
        end
      end
      fork
        if (use_p[0])
          port_burst(0, wv[0], av[0], wdv[0], 1'b0, rdv[0], adv[0],
                     nav[0], nrv[0], tav[0], trv[0], tdv[0], bov[0]);
        if (use_p[1])
          port_burst(1, wv[1], av[1], wdv[1], 1'b0, rdv[1], adv[1],
                     nav[1], nrv[1], tav[1], trv[1], tdv[1], bov[1]);
      join
      for (int p = 0; p < 2; p++) begin
        if (use_p[p]) begin
          n_checks++;
          if (tdv[p] < 0 || nav[p] != LW || bov[p] ||
              tdv[p] != tav[p] + LW - (wv[p] ? 1 : 0) ||
              nrv[p] != (wv[p] ? 0 : LW) ||
              (!wv[p] && trv[p] != tav[p] + 1))
            $display("FAIL rand%0d_p%0d_timing got w=%b na=%0d nr=%0d ta=%0d tr=%0d td=%0d bad=%b required handshake rules",
                     it, p, wv[p], nav[p], nrv[p], tav[p], trv[p], tdv[p], bov[p]);
          else n_pass++;
          for (int i = 0; i < LW; i++) begin
            n_checks++;
            if (adv[p][i] !== AW'(la[p] + i) ||
                (!wv[p] && rdv[p][i] !== expv[p][i]))
              $display("FAIL rand%0d_p%0d_beat%0d got addr=%h data=%h required %h/%h",
                       it, p, i, adv[p][i], rdv[p][i], AW'(la[p] + i), expv[p][i]);
            else n_pass++;
            if (wv[p]) ref_mem[la[p] + i] = wdv[p][i];
          end
        end
      end
      if (mode == 2) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = 1 - last_p;
`endif
        n_checks++;
        if (tav[1 - win] != tdv[win] + 2)
          $display("FAIL rand%0d_order got loser t_ack=%0d required %0d (winner %0d)",
                   it, tav[1 - win], tdv[win] + 2, win);
        else n_pass++;
        last_p = 1 - win;
      end else begin
        last_p = mode;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; rw[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
    for (int i = 0; i < 8192; i++) ref_mem[i] = 16'(i * 37 + 23130);
    test_reset();
    test_write_p0();
    test_read_p1();
    test_wrap();
    test_contention();
    test_stream();
    test_reset_mid_burst();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
